turbo_iter_ctrl: RTL and testbench
==================================

// Module: turbo_iter_ctrl
// PURPOSE
//  Iteration scheduler for the turbo decoder. Time-shares one Siso instance between the
//  two constituent half-iterations: natural order with parity 1, then interleaved order
//  with parity 2. Owns the extrinsic buffer, the interleave/deinterleave permutation,
//  the iteration counter and the final hard decision.
//  Sits between the frame input interface and the Siso datapath.
// PARAMETERS
//  N_SYM     7                 symbols per block (incl. 2 tail); fixed to Siso packing
//  MAX_ITER  4                 full iterations per block (1..15)
//  PERM      21'o0415263       interleaver; entry k = PERM[3k+2:3k] = source index, must be a permutation
// PORTS
//  clk_i          in   1   clock
//  reset_n_i      in   1   async active-low reset
//  start_i        in   1   start pulse; sampled only in IDLE
//  sys_i          in   28  systematic soft symbols; 4b signed each, sym k at [27-4k -: 4]
//  par1_i         in   28  parity-1 soft symbols, same packing
//  par2_i         in   28  parity-2 soft symbols (interleaved domain), same packing
//  busy_o         out  1   high from start accept until done_o
//  done_o         out  1   1-cycle pulse: llr_o/bits_o valid
//  llr_o          out  70  final LLRs, natural order; 10b signed, sym k at [69-10k -: 10]
//  bits_o         out  7   hard decisions; bit k = ~llr[k][9] (LLR >= 0 -> 1)
//  iter_o         out  4   iterations completed on last block
//  siso_read_en_o out  1   1-cycle pulse to Siso read_en_i
//  siso_sys_o     out  28  to Siso sys_i
//  siso_enc_o     out  28  to Siso enc_i
//  siso_ext_o     out  70  to Siso ext_i (a-priori)
//  siso_data_i    in   70  from Siso data_o
//  siso_finish_i  in   1   from Siso finish
// BEHAVIOUR
//  - Reset: state=IDLE; busy_o=0, done_o=0, siso_read_en_o=0, llr_o=0, bits_o=0, iter_o=0.
//    Extrinsic buffers are cleared to 0. Reset mid-block aborts without done_o.
//  - FSM states: IDLE -> LOAD -> ISSUE1 -> WAIT1 -> UPD1 -> ISSUE2 -> WAIT2 -> UPD2 ->
//    (ISSUE1 | OUT) -> IDLE.
//  - IDLE: on start_i, capture sys/par1/par2, clear ext2 buffer and iteration counter,
//    set busy_o=1, go to LOAD. start_i in any other state is ignored.
//  - LOAD: one cycle, then ISSUE1.
//  - ISSUE1: siso_read_en_o=1 for exactly 1 cycle.
//    siso_sys_o=sys, siso_enc_o=par1, siso_ext_o=ext2 (deinterleaved).
//    Next state: WAIT1.
//  - WAIT1/WAIT2: hold all siso_*_o stable; leave on siso_finish_i=1 (sampled).
//  - UPD1: ext1[k] = sat10(L[k] - sext(sys[k]) - ext2[k]).
//  - ISSUE2: siso_sys_o[k]=sys[PERM[k]], siso_enc_o=par2, siso_ext_o[k]=ext1[PERM[k]].
//  - UPD2: e = sat10(L[k] - sext(sys[PERM[k]]) - ext1[PERM[k]]); ext2[PERM[k]] = e.
//    Register llr[PERM[k]] = L[k]. Increment iter.
//    If iter==MAX_ITER go to OUT, else go to ISSUE1.
//  - OUT: llr_o, bits_o and iter_o update; done_o=1 for 1 cycle; busy_o falls the same
//    cycle; return to IDLE.
//  - Arithmetic: 12b signed intermediate; sat10 clamps to [-512,+511]. sys is sign-extended from 4b.
//  - Latency: per half-iteration = 1 (ISSUE) + Siso latency + 1 (UPD). Plus LOAD and OUT.
//    With Siso latency of 5 cycles this gives 7 cycles per half-iteration, 14*MAX_ITER+2 total.
//  - siso_finish_i outside WAIT1/WAIT2 is ignored.
// CONFIGURATION
//  TURBO_EARLY_STOP_EN defined:
//    - UPD2 compares the hard-decision vector against the previous iteration's vector.
//    - If equal and iter>=2, go to OUT early; iter_o reports the actual count.
//  Not defined: exactly MAX_ITER iterations, no compare logic.
// TESTING
//  - Reset: assert reset_n_i mid-WAIT2 -> next cycle busy_o=0, done_o=0, state IDLE;
//    a new start runs clean.
//  - Stub Siso (L=2*sys, latency 5), sys all +7, par 0, MAX_ITER=4 ->
//    done_o at cycle 58 after start; bits_o=7'h7F; iter_o=4.
//  - Interleave check: sys=sym k value k-3, stub echoes siso_sys_o as L ->
//    llr_o deinterleaves to natural order; ext buffers match PERM.
//  - Saturation: stub L=+511, sys=-8, ext=+511 -> ext clamps to +511, never wraps negative.
//  - Handshake: start_i held high 3 cycles -> one block only.
//    siso_finish_i pulse during ISSUE -> ignored.
//    siso_read_en_o is exactly 2*MAX_ITER single-cycle pulses.
//  - TURBO_EARLY_STOP_EN with a stable-decision stub -> done_o after 2 iterations, iter_o=2.
//    Without the macro -> iter_o=MAX_ITER.

Source files
------------

// File: rtl/turbo_iter_ctrl.sv
// rtl/turbo_iter_ctrl.sv - turbo decoder iteration scheduler around one shared Siso
//
// Purpose: time-shares a single Siso between the two constituent half-iterations
// (natural order with parity 1, then interleaved order with parity 2). Holds the
// captured block, both extrinsic buffers, the interleave permutation, the iteration
// counter and the final LLR / hard decision.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   start_i                     start pulse, only honoured in IDLE
//   sys_i, par1_i, par2_i       7 x 4b signed soft symbols, sym k at [27-4k -: 4]
//   busy_o, done_o              block in progress / 1-cycle result-valid pulse
//   llr_o, bits_o, iter_o       final LLRs (7 x 10b, natural order), hard bits, iterations run
//   siso_read_en_o              1-cycle launch pulse to the Siso
//   siso_sys_o/enc_o/ext_o      Siso operands, held stable while the Siso runs
//   siso_data_i, siso_finish_i  Siso result LLRs and completion flag
//
// Optional feature: define TURBO_EARLY_STOP_EN to stop once the hard decisions repeat
// between consecutive full iterations (never before the second iteration).

module turbo_iter_ctrl #(
  parameter int                 N_SYM    = 7,
  parameter int                 MAX_ITER = 4,
  parameter logic [3*N_SYM-1:0] PERM     = 21'o0415263
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [4*N_SYM-1:0]    sys_i,
  input  logic [4*N_SYM-1:0]    par1_i,
  input  logic [4*N_SYM-1:0]    par2_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [10*N_SYM-1:0]   llr_o,
  output logic [N_SYM-1:0]      bits_o,
  output logic [3:0]            iter_o,
  output logic                  siso_read_en_o,
  output logic [4*N_SYM-1:0]    siso_sys_o,
  output logic [4*N_SYM-1:0]    siso_enc_o,
  output logic [10*N_SYM-1:0]   siso_ext_o,
  input  logic [10*N_SYM-1:0]   siso_data_i,
  input  logic                  siso_finish_i
);

  localparam int SW = 4 * N_SYM;
  localparam int LW = 10 * N_SYM;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ISSUE1, S_WAIT1, S_UPD1, S_ISSUE2, S_WAIT2, S_UPD2, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0] sys_q, par1_q, par2_q;
  logic [LW-1:0] l_q;
  logic [9:0]    ext1_q [N_SYM];
  logic [9:0]    ext2_q [N_SYM];
  logic [3:0]    iter_q;
  logic [3:0]    iter_inc;
  logic          last_iter;
  logic          stop_early;

  logic [3:0]    sys_sym  [N_SYM];
  logic [9:0]    l_sym    [N_SYM];
  logic [9:0]    ext1_new [N_SYM];
  logic [9:0]    ext2_new [N_SYM];
  logic [9:0]    llr_nat  [N_SYM];
  logic [LW-1:0] llr_pack;
  logic [N_SYM-1:0] bits_new;

  // Source index feeding interleaved position k.
  function automatic logic [2:0] perm_at(input int k);
    return PERM[3*k +: 3];
  endfunction

  function automatic logic signed [11:0] sx4(input logic [3:0] x);
    return {{8{x[3]}}, x};
  endfunction

  function automatic logic signed [11:0] sx10(input logic [9:0] x);
    return {{2{x[9]}}, x};
  endfunction

  function automatic logic [9:0] sat10(input logic signed [11:0] x);
    if (x > 12'sd511)       return 10'h1ff;
    else if (x < -12'sd512) return 10'h200;
    else                    return x[9:0];
  endfunction

  assign iter_inc  = iter_q + 4'd1;
  assign last_iter = (iter_inc == 4'(MAX_ITER)) || stop_early;

  // Unpack operands and compute both extrinsic updates; the interleaved half
  // scatters its results back to natural positions through PERM.
  always_comb begin
    for (int k = 0; k < N_SYM; k++) begin
      sys_sym[k]  = sys_q[SW-1-4*k -: 4];
      l_sym[k]    = l_q[LW-1-10*k -: 10];
      ext2_new[k] = '0;
      llr_nat[k]  = '0;
    end
    for (int k = 0; k < N_SYM; k++) begin
      ext1_new[k] = sat10(sx10(l_sym[k]) - sx4(sys_sym[k]) - sx10(ext2_q[k]));
    end
    for (int k = 0; k < N_SYM; k++) begin
      ext2_new[perm_at(k)] = sat10(sx10(l_sym[k]) - sx4(sys_sym[perm_at(k)])
                                   - sx10(ext1_q[perm_at(k)]));
      llr_nat[perm_at(k)]  = l_sym[k];
    end
    llr_pack = '0;
    bits_new = '0;
    for (int k = 0; k < N_SYM; k++) begin
      llr_pack[LW-1-10*k -: 10] = llr_nat[k];
      bits_new[k]               = ~llr_nat[k][9];
    end
  end

  // Siso operands are a pure function of the phase; the buffers they read only
  // change in UPD states, so they stay stable throughout WAIT.
  always_comb begin
    siso_sys_o = sys_q;
    siso_enc_o = par1_q;
    siso_ext_o = '0;
    if (state_q == S_ISSUE2 || state_q == S_WAIT2) begin
      siso_enc_o = par2_q;
      for (int k = 0; k < N_SYM; k++) begin
        siso_sys_o[SW-1-4*k -: 4]  = sys_sym[perm_at(k)];
        siso_ext_o[LW-1-10*k -: 10] = ext1_q[perm_at(k)];
      end
    end else begin
      for (int k = 0; k < N_SYM; k++) begin
        siso_ext_o[LW-1-10*k -: 10] = ext2_q[k];
      end
    end
  end

`ifdef TURBO_EARLY_STOP_EN
  logic [N_SYM-1:0] prev_bits_q;
  assign stop_early = (bits_new == prev_bits_q) && (iter_inc >= 4'd2);
`else
  assign stop_early = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    siso_read_en_o = 1'b0;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_LOAD;
      S_LOAD:   state_d = S_ISSUE1;
      S_ISSUE1: begin
        siso_read_en_o = 1'b1;
        state_d        = S_WAIT1;
      end
      S_WAIT1:  if (siso_finish_i) state_d = S_UPD1;
      S_UPD1:   state_d = S_ISSUE2;
      S_ISSUE2: begin
        siso_read_en_o = 1'b1;
        state_d        = S_WAIT2;
      end
      S_WAIT2:  if (siso_finish_i) state_d = S_UPD2;
      S_UPD2:   state_d = last_iter ? S_OUT : S_ISSUE1;
      S_OUT:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sys_q  <= '0;
      par1_q <= '0;
      par2_q <= '0;
      l_q    <= '0;
      iter_q <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      llr_o  <= '0;
      bits_o <= '0;
      iter_o <= '0;
      for (int k = 0; k < N_SYM; k++) begin
        ext1_q[k] <= '0;
        ext2_q[k] <= '0;
      end
`ifdef TURBO_EARLY_STOP_EN
      prev_bits_q <= '0;
`endif
    end else begin
      // done_o follows entry into OUT so it lines up with the result registers.
      done_o <= (state_d == S_OUT);
      case (state_q)
        S_IDLE: if (start_i) begin
          sys_q  <= sys_i;
          par1_q <= par1_i;
          par2_q <= par2_i;
          iter_q <= '0;
          busy_o <= 1'b1;
          for (int k = 0; k < N_SYM; k++) ext2_q[k] <= '0;
        end
        S_WAIT1, S_WAIT2: if (siso_finish_i) l_q <= siso_data_i;
        S_UPD1: for (int k = 0; k < N_SYM; k++) ext1_q[k] <= ext1_new[k];
        S_UPD2: begin
          for (int k = 0; k < N_SYM; k++) ext2_q[k] <= ext2_new[k];
          iter_q <= iter_inc;
`ifdef TURBO_EARLY_STOP_EN
          prev_bits_q <= bits_new;
`endif
          if (last_iter) begin
            llr_o  <= llr_pack;
            bits_o <= bits_new;
            iter_o <= iter_inc;
            busy_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// tb/tb_turbo_iter_ctrl.sv - directed self-checking bench for turbo_iter_ctrl

module tb_turbo_iter_ctrl;

`ifdef TURBO_EARLY_STOP_EN
  localparam int EXP_ITER = 2;
`else
  localparam int EXP_ITER = 4;
`endif
  localparam int EXP_CYC    = 14 * EXP_ITER + 2;
  localparam int EXP_PULSES = 2 * EXP_ITER;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [27:0] sys, par1, par2;
  logic        busy, done;
  logic [69:0] llr;
  logic [6:0]  bits;
  logic [3:0]  iter;
  logic        rd_en;
  logic [27:0] s_sys, s_enc;
  logic [69:0] s_ext;
  logic [69:0] s_data;
  logic        s_fin;

  int n_checks = 0;
  int n_fail   = 0;

  // Siso stub control and observation.
  int          mode;
  logic        inj;
  logic [2:0]  cnt;
  int          rd_cnt;
  logic [27:0] snap_sys [16];
  logic [27:0] snap_enc [16];
  logic [69:0] snap_ext [16];

  always #5 clk = ~clk;

  turbo_iter_ctrl dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .start_i        (start),
    .sys_i          (sys),
    .par1_i         (par1),
    .par2_i         (par2),
    .busy_o         (busy),
    .done_o         (done),
    .llr_o          (llr),
    .bits_o         (bits),
    .iter_o         (iter),
    .siso_read_en_o (rd_en),
    .siso_sys_o     (s_sys),
    .siso_enc_o     (s_enc),
    .siso_ext_o     (s_ext),
    .siso_data_i    (s_data),
    .siso_finish_i  (s_fin)
  );

  function automatic logic [69:0] stub_l(input int m, input logic [27:0] s);
    logic [69:0]       r;
    logic signed [3:0] x;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      x = s[27-4*k -: 4];
      case (m)
        0:       r[69-10*k -: 10] = 10'(2 * int'(x));
        1:       r[69-10*k -: 10] = 10'(int'(x));
        default: r[69-10*k -: 10] = 10'd511;
      endcase
    end
    return r;
  endfunction

  function automatic logic [69:0] rep10(input logic [9:0] v);
    logic [69:0] r;
    for (int k = 0; k < 7; k++) r[69-10*k -: 10] = v;
    return r;
  endfunction

  // Stub Siso: 5-cycle latency, result chosen by mode; inj adds a stray
  // finish pulse during ISSUE which the DUT must ignore.
  always @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= 3'd0;
      rd_cnt <= 0;
      s_data <= '0;
    end else if (rd_en) begin
      cnt    <= 3'd1;
      s_data <= stub_l(mode, s_sys);
      if (rd_cnt < 16) begin
        snap_sys[rd_cnt] <= s_sys;
        snap_enc[rd_cnt] <= s_enc;
        snap_ext[rd_cnt] <= s_ext;
      end
      rd_cnt <= rd_cnt + 1;
    end else if (cnt == 3'd5) begin
      cnt <= 3'd0;
    end else if (cnt != 3'd0) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign s_fin = (cnt == 3'd5) | (inj & rd_en);

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Runs one block; cyc = cycle on which done_o is seen (start-accept cycle's
  // successor is cycle 1), or -1 on timeout.
  task automatic run_block(input logic [27:0] s, input logic [27:0] p1, input logic [27:0] p2,
                           input int m, input int hold, input logic inj_en, output int cyc);
    @(negedge clk);
    sys = s; par1 = p1; par2 = p2; mode = m; inj = inj_en;
    start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i >= hold) start = 1'b0;
      if (done) begin
        cyc = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  int          cyc;
  int          pulses;
  logic [69:0] exp_llr;

  initial begin
    reset_n = 1'b0; start = 1'b0; sys = '0; par1 = '0; par2 = '0; mode = 0; inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  70'(busy),  70'd0);
    check("rst_done",  70'(done),  70'd0);
    check("rst_rd_en", 70'(rd_en), 70'd0);
    check("rst_llr",   llr,        70'd0);
    check("rst_bits",  70'(bits),  70'd0);
    check("rst_iter",  70'(iter),  70'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Abort in WAIT2.
    @(negedge clk);
    sys = 28'h7777777; par1 = '0; par2 = '0; mode = 0; inj = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rd_cnt == 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("mid_busy_before", 70'(busy), 70'd1);
    reset_n = 1'b0;
    #1;
    check("mid_busy",  70'(busy),  70'd0);
    check("mid_done",  70'(done),  70'd0);
    check("mid_rd_en", 70'(rd_en), 70'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Nominal block: start held 3 cycles, stray finish during ISSUE.
    run_block(28'h7777777, 28'h0, 28'h0, 0, 3, 1'b1, cyc);
    check("a_done_cycle", 70'(cyc),  70'(EXP_CYC));
    check("a_bits",       70'(bits), 70'h7f);
    check("a_iter",       70'(iter), 70'(EXP_ITER));
    check("a_llr",        llr,       rep10(10'd14));
    check("a_busy_at_done", 70'(busy), 70'd0);
    check("a_ext_issue2", snap_ext[1], rep10(10'd7));
    @(negedge clk);
    check("a_done_pulse", 70'(done), 70'd0);
    pulses = rd_cnt;
    check("a_read_pulses", 70'(pulses), 70'(EXP_PULSES));
    repeat (20) @(negedge clk);
    check("a_no_rerun_busy", 70'(busy),   70'd0);
    check("a_no_rerun_rd",   70'(rd_cnt), 70'(EXP_PULSES));

    // Interleave: sys sym k = k-3, stub echoes siso_sys_o.
    do_reset();
    run_block(28'hDEF0123, 28'h1234567, 28'h7654321, 1, 1, 1'b0, cyc);
    for (int k = 0; k < 7; k++) exp_llr[69-10*k -: 10] = 10'(k - 3);
    check("i_done_cycle", 70'(cyc),  70'(EXP_CYC));
    check("i_llr",        llr,       exp_llr);
    check("i_bits",       70'(bits), 70'h78);
    check("i_sys_nat",    70'(snap_sys[0]), 70'h0DEF0123);
    check("i_enc_nat",    70'(snap_enc[0]), 70'h01234567);
    check("i_sys_perm",   70'(snap_sys[1]), 70'h003F2E1D);
    check("i_enc_perm",   70'(snap_enc[1]), 70'h07654321);
    check("i_ext_perm",   snap_ext[1], 70'd0);

    // Saturation: L=+511, sys=-8 drives ext1 to 519 before clamping.
    do_reset();
    run_block(28'h8888888, 28'h0, 28'h0, 2, 1, 1'b0, cyc);
    check("s_done_cycle", 70'(cyc),  70'(EXP_CYC));
    check("s_ext1_clamp", snap_ext[1], rep10(10'h1ff));
    check("s_ext2_iter2", snap_ext[2], rep10(10'd8));
    check("s_llr",        llr,       rep10(10'h1ff));
    check("s_bits",       70'(bits), 70'h7f);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
